// File: rtl/pcie_tl_cpl_tracker.sv
`default_nettype none
// ============================================================================
// Module   : pcie_tl_cpl_tracker
// Brief    : Completer-side TLP engine. Accepts Memory Read request headers,
//            tracks them in a slot table, hands them to the application, and
//            converts the application's multi-beat completion data into CplD
//            TLPs on a backpressured TX stream.
// Ports    : clk/rst            - clock, synchronous active-high reset
//            rx_req_*           - request header stream from the DLL
//            app_req_*          - request handed to the application
//            app_cpl_*          - completion data beats from the application
//            tx_*               - CplD TLP stream towards the DLL
//            outstanding_cnt    - number of occupied slots
//            err_unexp_cpl      - pulse: completion started on an empty slot
//            err_unsup_req      - pulse: non-MRd request discarded
// Revision : 1.0 - initial release
// ============================================================================
module pcie_tl_cpl_tracker #(
    parameter int          DATA_WIDTH   = 256,
    parameter int          HDR_WIDTH    = 128,
    parameter int          NUM_TAGS     = 8,
    parameter logic [15:0] COMPLETER_ID = 16'h0100
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx_req_valid,
    output logic                          rx_req_ready,
    input  logic [HDR_WIDTH-1:0]          rx_req_header,
    output logic                          app_req_valid,
    input  logic                          app_req_ready,
    output logic [$clog2(NUM_TAGS)-1:0]   app_req_slot,
    output logic [63:0]                   app_req_addr,
    output logic [10:0]                   app_req_len,
    input  logic                          app_cpl_valid,
    output logic                          app_cpl_ready,
    input  logic [$clog2(NUM_TAGS)-1:0]   app_cpl_slot,
    input  logic [DATA_WIDTH-1:0]         app_cpl_data,
    input  logic                          app_cpl_last,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic [HDR_WIDTH-1:0]          tx_header,
    output logic [DATA_WIDTH-1:0]         tx_data,
    output logic                          tx_sop,
    output logic                          tx_eop,
    output logic [$clog2(NUM_TAGS):0]     outstanding_cnt,
    output logic                          err_unexp_cpl,
    output logic                          err_unsup_req
);

    localparam int SLOT_W = $clog2(NUM_TAGS);
    localparam int CNT_W  = SLOT_W + 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_DROP   = 2'd2;

    // Slot table: valid bits are reset, payload fields are only meaningful
    // while the corresponding valid bit is set.
    logic [NUM_TAGS-1:0] r_slot_vld;
    logic [15:0]         r_slot_reqid [NUM_TAGS];
    logic [7:0]          r_slot_tag   [NUM_TAGS];
    logic [9:0]          r_slot_len   [NUM_TAGS];
    logic [6:0]          r_slot_lad   [NUM_TAGS];

    logic [1:0]            r_state;
    logic [SLOT_W-1:0]     r_cur_slot;
    logic [CNT_W-1:0]      r_outstanding;
    logic                  r_app_req_valid;
    logic [SLOT_W-1:0]     r_app_req_slot;
    logic [63:0]           r_app_req_addr;
    logic [10:0]           r_app_req_len;
    logic                  r_tx_valid;
    logic [HDR_WIDTH-1:0]  r_tx_header;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic                  r_tx_sop;
    logic                  r_tx_eop;
    logic                  r_err_unexp;
    logic                  r_err_unsup;

    logic [9:0]            w_len_field;
    logic                  w_is_mrd;
    logic                  w_rx_acc;
    logic                  w_alloc;
    logic [SLOT_W-1:0]     w_alloc_slot;
    logic                  w_cpl_ready;
    logic                  w_cpl_acc;
    logic                  w_first;
    logic                  w_hit;
    logic                  w_emit;
    logic                  w_free;
    logic [SLOT_W-1:0]     w_free_slot;
    logic [HDR_WIDTH-1:0]  w_cpl_hdr;

    // ---------------- request side ----------------
    assign w_len_field = rx_req_header[109:100];
    assign w_is_mrd    = (rx_req_header[127:126] == 2'b00) && (rx_req_header[124:120] == 5'b00000);
    assign rx_req_ready = (~&r_slot_vld) & ~r_app_req_valid;
    assign w_rx_acc    = rx_req_valid & rx_req_ready;
    assign w_alloc     = w_rx_acc & w_is_mrd;

    // Lowest free slot: descending scan so the lowest index is written last.
    always_comb begin
        w_alloc_slot = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (!r_slot_vld[i]) begin
                w_alloc_slot = SLOT_W'(i);
            end
        end
    end

    // ---------------- completion side ----------------
    assign w_cpl_ready = ~r_tx_valid | tx_ready;
    assign w_cpl_acc   = app_cpl_valid & w_cpl_ready;
    assign w_first     = (r_state == S_IDLE);
    assign w_hit       = r_slot_vld[app_cpl_slot];
    assign w_emit      = w_cpl_acc & ((w_first & w_hit) | (r_state == S_STREAM));
    assign w_free      = w_emit & app_cpl_last;
    // The slot number is only presented on the first beat; later beats use
    // the slot captured then.
    assign w_free_slot = w_first ? app_cpl_slot : r_cur_slot;

    always_comb begin
        w_cpl_hdr            = '0;
        w_cpl_hdr[127:125]   = 3'b010;
        w_cpl_hdr[124:120]   = 5'b01010;
        w_cpl_hdr[109:100]   = r_slot_len[app_cpl_slot];
        w_cpl_hdr[95:80]     = COMPLETER_ID;
        // Byte count is length*4 in 12 bits; a 1024-DW request wraps to 0.
        w_cpl_hdr[75:64]     = {r_slot_len[app_cpl_slot], 2'b00};
        w_cpl_hdr[63:48]     = r_slot_reqid[app_cpl_slot];
        w_cpl_hdr[47:40]     = r_slot_tag[app_cpl_slot];
        w_cpl_hdr[38:32]     = r_slot_lad[app_cpl_slot];
    end

    // Slot payload storage, written only on allocation.
    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_slot_reqid[w_alloc_slot] <= rx_req_header[95:80];
            r_slot_tag[w_alloc_slot]   <= rx_req_header[79:72];
            r_slot_len[w_alloc_slot]   <= w_len_field;
            r_slot_lad[w_alloc_slot]   <= rx_req_header[6:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot_vld      <= '0;
            r_state         <= S_IDLE;
            r_cur_slot      <= '0;
            r_outstanding   <= '0;
            r_app_req_valid <= 1'b0;
            r_app_req_slot  <= '0;
            r_app_req_addr  <= '0;
            r_app_req_len   <= '0;
            r_tx_valid      <= 1'b0;
            r_tx_header     <= '0;
            r_tx_data       <= '0;
            r_tx_sop        <= 1'b0;
            r_tx_eop        <= 1'b0;
            r_err_unexp     <= 1'b0;
            r_err_unsup     <= 1'b0;
        end else begin
            // Free and allocate never hit the same slot: allocation picks from
            // the pre-edge free vector, freeing targets a currently valid slot.
            if (w_free) begin
                r_slot_vld[w_free_slot] <= 1'b0;
            end
            if (w_alloc) begin
                r_slot_vld[w_alloc_slot] <= 1'b1;
            end

            case ({w_alloc, w_free})
                2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
                2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
                default: r_outstanding <= r_outstanding;
            endcase

            if (w_alloc) begin
                r_app_req_valid <= 1'b1;
                r_app_req_slot  <= w_alloc_slot;
                r_app_req_addr  <= rx_req_header[63:0];
                r_app_req_len   <= {(w_len_field == 10'd0), w_len_field};
            end else if (app_req_ready) begin
                r_app_req_valid <= 1'b0;
            end

            r_err_unsup <= w_rx_acc & ~w_is_mrd;
            r_err_unexp <= w_cpl_acc & w_first & ~w_hit;

            if (w_cpl_acc) begin
                case (r_state)
                    S_IDLE: begin
                        if (w_hit) begin
                            r_cur_slot <= app_cpl_slot;
                            if (!app_cpl_last) r_state <= S_STREAM;
                        end else if (!app_cpl_last) begin
                            r_state <= S_DROP;
                        end
                    end
                    S_STREAM, S_DROP: begin
                        if (app_cpl_last) r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end

            // Output register loads whenever it is empty or being drained.
            if (w_cpl_ready) begin
                r_tx_valid  <= w_emit;
                r_tx_sop    <= w_emit & w_first;
                r_tx_eop    <= w_emit & app_cpl_last;
                r_tx_data   <= w_emit ? app_cpl_data : '0;
                r_tx_header <= (w_emit & w_first) ? w_cpl_hdr : '0;
            end
        end
    end

    assign app_req_valid   = r_app_req_valid;
    assign app_req_slot    = r_app_req_slot;
    assign app_req_addr    = r_app_req_addr;
    assign app_req_len     = r_app_req_len;
    assign app_cpl_ready   = w_cpl_ready;
    assign tx_valid        = r_tx_valid;
    assign tx_header       = r_tx_header;
    assign tx_data         = r_tx_data;
    assign tx_sop          = r_tx_sop;
    assign tx_eop          = r_tx_eop;
    assign outstanding_cnt = r_outstanding;
    assign err_unexp_cpl   = r_err_unexp;
    assign err_unsup_req   = r_err_unsup;

endmodule
`default_nettype wire

// File: tb/tb_pcie_tl_cpl_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcie_tl_cpl_tracker
// Brief    : Scoreboard bench for pcie_tl_cpl_tracker. Expected TX beats and
//            application requests are queued by the stimulus; a monitor pops
//            and compares them at each handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcie_tl_cpl_tracker;

    localparam int DW = 256;

    logic           clk = 1'b0;
    logic           rst;
    logic           rx_req_valid;
    logic           rx_req_ready;
    logic [127:0]   rx_req_header;
    logic           app_req_valid;
    logic           app_req_ready;
    logic [2:0]     app_req_slot;
    logic [63:0]    app_req_addr;
    logic [10:0]    app_req_len;
    logic           app_cpl_valid;
    logic           app_cpl_ready;
    logic [2:0]     app_cpl_slot;
    logic [DW-1:0]  app_cpl_data;
    logic           app_cpl_last;
    logic           tx_valid;
    logic           tx_ready;
    logic [127:0]   tx_header;
    logic [DW-1:0]  tx_data;
    logic           tx_sop;
    logic           tx_eop;
    logic [3:0]     outstanding_cnt;
    logic           err_unexp_cpl;
    logic           err_unsup_req;

    pcie_tl_cpl_tracker #(
        .DATA_WIDTH   (DW),
        .HDR_WIDTH    (128),
        .NUM_TAGS     (8),
        .COMPLETER_ID (16'h0100)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .rx_req_valid    (rx_req_valid),
        .rx_req_ready    (rx_req_ready),
        .rx_req_header   (rx_req_header),
        .app_req_valid   (app_req_valid),
        .app_req_ready   (app_req_ready),
        .app_req_slot    (app_req_slot),
        .app_req_addr    (app_req_addr),
        .app_req_len     (app_req_len),
        .app_cpl_valid   (app_cpl_valid),
        .app_cpl_ready   (app_cpl_ready),
        .app_cpl_slot    (app_cpl_slot),
        .app_cpl_data    (app_cpl_data),
        .app_cpl_last    (app_cpl_last),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready),
        .tx_header       (tx_header),
        .tx_data         (tx_data),
        .tx_sop          (tx_sop),
        .tx_eop          (tx_eop),
        .outstanding_cnt (outstanding_cnt),
        .err_unexp_cpl   (err_unexp_cpl),
        .err_unsup_req   (err_unsup_req)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [127:0]  hdr;
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
    } tx_exp_t;

    typedef struct packed {
        logic [2:0]  slot;
        logic [63:0] addr;
        logic [10:0] len;
    } req_exp_t;

    tx_exp_t  tx_q  [$];
    req_exp_t req_q [$];

    int n_chk  = 0;
    int n_fail = 0;
    int n_unexp = 0;
    int n_unsup = 0;

    // Per-slot record of what the bench issued, used to build expected CplD.
    logic [9:0]  sl_len [8];
    logic [15:0] sl_rid [8];
    logic [7:0]  sl_tag [8];
    logic [6:0]  sl_lad [8];

    task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    function automatic logic [127:0] mk_req(input logic [2:0] fmt, input logic [4:0] typ,
                                            input logic [9:0] len, input logic [15:0] rid,
                                            input logic [7:0] tag, input logic [63:0] addr);
        logic [127:0] h;
        h = '0;
        h[127:125] = fmt;
        h[124:120] = typ;
        h[109:100] = len;
        h[95:80]   = rid;
        h[79:72]   = tag;
        h[63:0]    = addr;
        return h;
    endfunction

    function automatic logic [127:0] exp_cpl(input int s);
        logic [127:0] h;
        h = '0;
        h[127:125] = 3'b010;
        h[124:120] = 5'b01010;
        h[109:100] = sl_len[s];
        h[95:80]   = 16'h0100;
        h[75:64]   = {sl_len[s], 2'b00};
        h[63:48]   = sl_rid[s];
        h[47:40]   = sl_tag[s];
        h[38:32]   = sl_lad[s];
        return h;
    endfunction

    function automatic logic [DW-1:0] bdata(input logic [31:0] base, input int b);
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = base + 32'(b * 16 + i);
        return d;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic [127:0] h, input bit is_mrd, input logic [2:0] slot,
                            input logic [10:0] len);
        int n;
        if (is_mrd) req_q.push_back('{slot: slot, addr: h[63:0], len: len});
        rx_req_header = h;
        rx_req_valid  = 1'b1;
        n = 0;
        @(negedge clk);
        while (!rx_req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("rx_req_timeout", 1, 0);
        @(posedge clk);
        #1;
        rx_req_valid = 1'b0;
    endtask

    task automatic send_mrd(input logic [2:0] fmt, input logic [9:0] len, input logic [15:0] rid,
                            input logic [7:0] tag, input logic [63:0] addr, input logic [2:0] slot);
        sl_len[slot] = len;
        sl_rid[slot] = rid;
        sl_tag[slot] = tag;
        sl_lad[slot] = addr[6:0];
        send_req(mk_req(fmt, 5'b00000, len, rid, tag, addr), 1'b1, slot,
                 (len == 10'd0) ? 11'd1024 : {1'b0, len});
    endtask

    task automatic send_beat(input logic [2:0] slot, input logic [DW-1:0] d, input bit last);
        int n;
        app_cpl_valid = 1'b1;
        app_cpl_slot  = slot;
        app_cpl_data  = d;
        app_cpl_last  = last;
        n = 0;
        @(negedge clk);
        while (!app_cpl_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("cpl_ready_timeout", 1, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic send_cpl(input logic [2:0] slot, input int nb, input logic [31:0] base,
                            input bit emit, input logic [127:0] hdr);
        for (int b = 0; b < nb; b++) begin
            if (emit) tx_q.push_back('{hdr: (b == 0) ? hdr : 128'h0, data: bdata(base, b),
                                       sop: (b == 0), eop: (b == nb - 1)});
            send_beat(slot, bdata(base, b), b == nb - 1);
        end
        app_cpl_valid = 1'b0;
        app_cpl_last  = 1'b0;
    endtask

    task automatic do_cpl(input int s, input int nb, input logic [31:0] base);
        send_cpl(3'(s), nb, base, 1'b1, exp_cpl(s));
    endtask

    // Monitor: compares every TX and application-request handshake against
    // the queues, and counts error pulses.
    always @(negedge clk) begin
        if (!rst) begin
            if (tx_valid && tx_ready) begin
                if (tx_q.size() == 0) begin
                    chk("tx_unexpected_beat", {tx_valid, tx_data[31:0]}, 0);
                end else begin
                    tx_exp_t e;
                    e = tx_q.pop_front();
                    chk("tx_header", tx_header, e.hdr);
                    chk("tx_data", tx_data, e.data);
                    chk("tx_sop", tx_sop, e.sop);
                    chk("tx_eop", tx_eop, e.eop);
                end
            end
            if (app_req_valid && app_req_ready) begin
                if (req_q.size() == 0) begin
                    chk("app_req_unexpected", {app_req_valid, app_req_addr}, 0);
                end else begin
                    req_exp_t r;
                    r = req_q.pop_front();
                    chk("app_req_slot", app_req_slot, r.slot);
                    chk("app_req_addr", app_req_addr, r.addr);
                    chk("app_req_len", app_req_len, r.len);
                end
            end
            if (err_unexp_cpl) n_unexp++;
            if (err_unsup_req) n_unsup++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int e0;
        rst           = 1'b1;
        rx_req_valid  = 1'b0;
        rx_req_header = '0;
        app_req_ready = 1'b1;
        app_cpl_valid = 1'b0;
        app_cpl_slot  = '0;
        app_cpl_data  = '0;
        app_cpl_last  = 1'b0;
        tx_ready      = 1'b1;
        idle(3);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_app_req_valid", app_req_valid, 0);
        chk("rst_outstanding", outstanding_cnt, 0);
        chk("rst_err", {err_unexp_cpl, err_unsup_req}, 0);
        rst = 1'b0;
        idle(1);

        // 1: basic MRd and single-beat completion with a hand-built header.
        send_mrd(3'b000, 10'd4, 16'h0A01, 8'h12, 64'h0000_0000_1000_0044, 3'd0);
        chk("t1_app_req_valid", app_req_valid, 1);
        chk("t1_app_req_slot", app_req_slot, 0);
        chk("t1_app_req_len", app_req_len, 4);
        chk("t1_outstanding", outstanding_cnt, 1);
        send_cpl(3'd0, 1, 32'hA000_0000, 1'b1, 128'h4A000040_01000010_0A011244_00000000);
        idle(2);
        chk("t1_outstanding_end", outstanding_cnt, 0);

        // 2: fill all slots, free slot 3, reuse it.
        for (int i = 0; i < 8; i++)
            send_mrd(3'b001, 10'(i + 1), 16'h0B00 + 16'(i), 8'h20 + 8'(i),
                     64'h2_0000_0000 + 64'(i * 256 + i * 9), 3'(i));
        idle(1);
        chk("t2_outstanding_full", outstanding_cnt, 8);
        chk("t2_rx_ready_full", rx_req_ready, 0);
        do_cpl(3, 1, 32'hB300_0000);
        chk("t2_rx_ready_after_free", rx_req_ready, 1);
        send_mrd(3'b000, 10'd2, 16'h0C00, 8'h40, 64'h0000_0000_3000_007F, 3'd3);
        chk("t2_reuse_slot", app_req_slot, 3);
        idle(1);
        chk("t2_outstanding_refill", outstanding_cnt, 8);
        for (int s = 0; s < 8; s++) do_cpl(s, 1, 32'hB000_0000 + 32'(s << 20));
        idle(3);
        chk("t2_outstanding_drained", outstanding_cnt, 0);

        // 3: three-beat completion with a four-cycle TX stall mid-packet.
        send_mrd(3'b000, 10'd24, 16'h0D0D, 8'h55, 64'h0000_0000_4000_0010, 3'd0);
        fork
            do_cpl(0, 3, 32'hC000_0000);
            begin
                repeat (2) @(posedge clk);
                #1;
                tx_ready = 1'b0;
                repeat (4) begin
                    @(posedge clk);
                    #1;
                    chk("t3_hold_valid", tx_valid, 1);
                    chk("t3_hold_data", tx_data, bdata(32'hC000_0000, 1));
                    chk("t3_hold_sop", tx_sop, 0);
                    chk("t3_hold_cpl_ready", app_cpl_ready, 0);
                end
                tx_ready = 1'b1;
            end
        join
        idle(3);
        chk("t3_outstanding", outstanding_cnt, 0);

        // 4: completion on an empty slot is dropped with one error pulse.
        e0 = n_unexp;
        send_cpl(3'd5, 2, 32'hD000_0000, 1'b0, 128'h0);
        idle(2);
        chk("t4_unexp_pulses", n_unexp, e0 + 1);
        chk("t4_tx_valid", tx_valid, 0);
        send_mrd(3'b000, 10'd16, 16'h0E0E, 8'h66, 64'h0000_0000_5000_0020, 3'd0);
        do_cpl(0, 2, 32'hD100_0000);
        idle(3);
        chk("t4_outstanding", outstanding_cnt, 0);

        // 5: MWr discarded; zero-length MRd means 1024 DW, byte count 0.
        e0 = n_unsup;
        send_req(mk_req(3'b010, 5'b00000, 10'd1, 16'h0F0F, 8'h77, 64'h6000_0000), 1'b0, 3'd0, 11'd0);
        idle(2);
        chk("t5_unsup_pulses", n_unsup, e0 + 1);
        chk("t5_outstanding", outstanding_cnt, 0);
        chk("t5_app_req_valid", app_req_valid, 0);
        send_mrd(3'b000, 10'd0, 16'h1111, 8'h88, 64'h0000_0000_7000_0008, 3'd0);
        chk("t5_len_1024", app_req_len, 11'd1024);
        do_cpl(0, 1, 32'hE000_0000);
        chk("t5_bytecount", tx_header[75:64], 0);
        chk("t5_hdr_len", tx_header[109:100], 0);
        idle(3);

        // 6: reset in the middle of a three-beat packet.
        send_mrd(3'b000, 10'd24, 16'h2222, 8'h99, 64'h0000_0000_8000_0004, 3'd0);
        tx_q.push_back('{hdr: exp_cpl(0), data: bdata(32'hF000_0000, 0), sop: 1'b1, eop: 1'b0});
        send_beat(3'd0, bdata(32'hF000_0000, 0), 1'b0);
        send_beat(3'd0, bdata(32'hF000_0000, 1), 1'b0);
        rst = 1'b1;
        app_cpl_valid = 1'b0;
        idle(1);
        chk("t6_tx_valid", tx_valid, 0);
        chk("t6_outstanding", outstanding_cnt, 0);
        rst = 1'b0;
        idle(1);
        send_mrd(3'b000, 10'd1, 16'h3333, 8'hAA, 64'h0000_0000_9000_0001, 3'd0);
        chk("t6_new_slot", app_req_slot, 0);
        do_cpl(0, 1, 32'h1234_0000);
        idle(3);
        chk("t6_outstanding_end", outstanding_cnt, 0);
        chk("tx_queue_empty", tx_q.size(), 0);
        chk("req_queue_empty", req_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pcie_tl_cpl_tracker.md
Name: pcie_tl_cpl_tracker

Overview:
Parametrised completer-side transaction-layer engine with outstanding-request tracking.
- Accepts Memory Read request TLPs from the data link layer and records each request in a slot table (NUM_TAGS deep).
- Forwards each request to the application with a slot index.
- Turns the application's multi-beat completion data into correctly formed CplD TLPs on a ready/valid TX stream with full backpressure.
- Sits between the DLL RX/TX streams and the application request/completion interface.

Parameters:
DATA_WIDTH, 256, TX/completion data beat width in bits; multiple of 32
HDR_WIDTH, 128, TLP header width; layout fixed at 128
NUM_TAGS, 8, outstanding request slots; power of two, 2..32
COMPLETER_ID, 16'h0100, completer ID inserted into CplD headers

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
rx_req_valid  in  1  request TLP header valid
rx_req_ready  out  1  engine can accept a request this cycle
rx_req_header  in  HDR_WIDTH  request header
app_req_valid  out  1  request to application valid
app_req_ready  in  1  application accepts request
app_req_slot  out  log2(NUM_TAGS)  slot index of request
app_req_addr  out  64  request address
app_req_len  out  11  length in DW, 1..1024
app_cpl_valid  in  1  completion data beat valid
app_cpl_ready  out  1  beat accepted when valid and ready
app_cpl_slot  in  log2(NUM_TAGS)  slot for this completion; sampled on first beat only
app_cpl_data  in  DATA_WIDTH  completion payload beat
app_cpl_last  in  1  final beat of completion
tx_valid  out  1  TX beat valid
tx_ready  in  1  DLL accepts TX beat
tx_header  out  HDR_WIDTH  CplD header; valid only when tx_sop=1, else 0
tx_data  out  DATA_WIDTH  TX payload
tx_sop  out  1  first beat of TLP
tx_eop  out  1  last beat of TLP
outstanding_cnt  out  log2(NUM_TAGS)+1  number of valid slots
err_unexp_cpl  out  1  one-cycle pulse: first completion beat names an empty slot
err_unsup_req  out  1  one-cycle pulse: non-MRd request accepted and discarded

Behaviour:
- Reset is synchronous on rst=1:
  - all slots invalid; FSM to IDLE.
  - all outputs 0: tx_*, app_req_*, err_*, outstanding_cnt.
  - any in-flight TX packet is truncated with no eop.
- RX header fields:
  - fmt [127:125], type [124:120], length [109:100] (0 encodes 1024), requester_id [95:80], tag [79:72], address [63:0].
  - MRd is fmt 000 or 001 with type 00000.
- rx_req_ready = (any slot free) AND (app_req_valid=0).
- On rx_req_valid & rx_req_ready with an MRd:
  - allocate the lowest free slot at that edge, storing requester_id, tag, length and address[6:0].
  - app_req_valid rises next cycle; slot/addr/len are held stable until app_req_ready.
- On rx_req_valid & rx_req_ready with a non-MRd: discard the request, pulse err_unsup_req next cycle, allocate no slot.
- Allocation uses the pre-edge free vector, so a slot freed at the same edge is not reusable until the next cycle. Simultaneous allocate and free leaves outstanding_cnt unchanged.
- TX output register: app_cpl_ready = (tx_valid=0) OR tx_ready. Each accepted beat appears on tx_* the next cycle, so latency is 1 cycle. tx_* hold while tx_valid & !tx_ready.
- FSM states and transitions:
  - IDLE: on an accepted first beat, if app_cpl_slot is valid, emit tx_sop=1 with the header and tx_eop=app_cpl_last, then go to STREAM (or stay IDLE if last). If the slot is invalid, consume the beat without emitting, pulse err_unexp_cpl, and go to DROP (or stay IDLE if last).
  - STREAM: forward beats with tx_sop=0; app_cpl_slot is ignored; tx_eop=app_cpl_last. The last beat returns the FSM to IDLE.
  - DROP: consume beats silently; last returns to IDLE.
- The slot is freed at the edge where its last beat is accepted from the application.
- CplD header layout:
  - [127:125]=010, [124:120]=01010, [119:110]=0, [109:100]=stored length, [99:96]=0.
  - [95:80]=COMPLETER_ID, [79:77]=000 (SC), [76]=0.
  - [75:64]=byte count = length*4 truncated to 12 bits (so 4096 encodes as 0).
  - [63:48]=requester_id, [47:40]=tag, [39]=0, [38:32]=lower address, [31:0]=0.
- The application must not interleave completions. Beat count against length is not checked.

Test Plan:
- Reset, then MRd len=4, addr=0x1000_0044, reqid=0x0A01, tag=0x12 -> app_req_valid one cycle later with slot 0, len 4; single-beat completion -> tx header: length 4, byte count 16, reqid 0x0A01, tag 0x12, lower addr 0x44, sop=eop=1; outstanding_cnt returns 0.
- Issue 8 MRd without completions -> slots 0..7 allocated; rx_req_ready=0 with outstanding_cnt=8; completing slot 3 makes rx_req_ready=1 the next cycle and the next request gets slot 3.
- 3-beat completion with tx_ready low for 4 cycles mid-packet -> tx beats held stable, no beat lost or duplicated, sop only on beat 0, eop only on beat 2.
- Completion naming an empty slot 5 (2 beats) -> no tx_valid, one err_unexp_cpl pulse, FSM back in IDLE ready for a valid completion.
- MWr header (fmt 010, type 00000) -> accepted, err_unsup_req pulse, outstanding_cnt unchanged; length field 0 on MRd -> app_req_len 1024, CplD byte count 0.
- rst asserted mid-packet after beat 1 of 3 -> next cycle tx_valid=0, outstanding_cnt=0, and a new request gets slot 0.
